pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded on reset, start and restart.
REQ-002 Parameter PC_STEP, default 4, SHALL be the sequential PC increment in bytes.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL begin fetching from IDLE or HALT when high for one cycle.
REQ-006 imem_req  output  1  SHALL be the instruction-memory read request.
REQ-007 imem_addr  output  32  SHALL be the fetch address, equal to pc_reg while imem_req=1.
REQ-008 imem_ack  input  1  SHALL be the memory completion strobe; imem_rdata is valid in the same cycle.
REQ-009 imem_rdata  input  32  SHALL be the fetched instruction word.
REQ-010 instr  output  32  SHALL be the held instruction.
REQ-011 instr_pc  output  32  SHALL be the address of instr.
REQ-012 instr_valid  output  1  SHALL flag that instr/instr_pc are valid.
REQ-013 instr_ready  input  1  SHALL be the consumer's retirement handshake for the held instruction.
REQ-014 finish_flag  input  1  SHALL request a halt after the current instruction; sampled with instr_ready.
REQ-015 branch  input  1  SHALL request a PC-relative redirect; sampled with instr_ready.
REQ-016 branch_offset  input  32 signed  SHALL be the byte offset added to instr_pc when branch is taken.
REQ-017 jump  input  1  SHALL request an absolute redirect; sampled with instr_ready.
REQ-018 jump_target  input  32  SHALL be the absolute jump address.
REQ-019 halted  output  1  SHALL be high in HALT.
REQ-020 misalign_err  output  1  SHALL be a sticky flag set when a redirect target has bits[1:0] != 0.
REQ-021 retired_count  output  32  SHALL count retired instructions.

Function
REQ-022 FSM states SHALL be IDLE, REQ, WAIT, HOLD, HALT.
REQ-023 IDLE: imem_req=0, instr_valid=0; start -> pc_reg=RESET_PC, go to REQ.
REQ-024 REQ: imem_req=1; if imem_ack, latch instr=imem_rdata and instr_pc=pc_reg, go to HOLD; otherwise go to WAIT.
REQ-025 WAIT: imem_req held at 1, imem_addr stable; on imem_ack, latch and go to HOLD.
REQ-026 HOLD: instr_valid=1, imem_req=0; instr/instr_pc stable until instr_ready=1.
REQ-027 On the HOLD cycle with instr_ready=1, the next PC SHALL use priority jump > branch > sequential: jump_target, instr_pc+branch_offset, or instr_pc+PC_STEP.
REQ-028 On that same cycle, finish_flag=1 SHALL go to HALT with pc_reg unchanged; otherwise the FSM SHALL go to REQ with the next PC, giving one idle cycle between retire and the next request.
REQ-029 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 = 0, and negative offsets wrap.
REQ-030 A misaligned redirect target SHALL have bits[1:0] forced to 0 and SHALL set misalign_err, which clears only on reset.
REQ-031 retired_count SHALL increment by 1 on each HOLD cycle with instr_ready=1, including the finishing instruction, and SHALL wrap at 2^32.
REQ-032 HALT: halted=1, no requests; start -> pc_reg=RESET_PC and go to REQ; retired_count is kept.
REQ-033 start outside IDLE/HALT SHALL be ignored; branch/jump/finish_flag outside HOLD with instr_ready SHALL be ignored.

Reset
REQ-034 reset=0 SHALL immediately force IDLE, pc_reg=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0, halted=0, misalign_err=0, retired_count=0, including mid-WAIT; an imem_ack arriving after reset SHALL be ignored.

Structure
REQ-035 The state enum, PC_STEP and the default RESET_PC SHALL live in shared package riscv_pkg.
REQ-036 Next-PC selection and alignment SHALL be a combinational sub-module pc_next_calc.

Verification
REQ-037 Check: start with zero-wait memory -> requests at 0, 4, 8; retired_count=3 after three instr_ready handshakes.
REQ-038 Check: ack delayed 3 cycles -> imem_req and imem_addr stable for 4 cycles; instr_valid rises the cycle after ack.
REQ-039 Check: instr_pc=0x10 with branch=1, offset=-8 -> next imem_addr=0x08; same instruction with jump=1, target=0x100 -> 0x100 wins.
REQ-040 Check: jump_target=0x102 -> imem_addr=0x100, misalign_err=1 and still set after later fetches.
REQ-041 Check: pc_reg=0xFFFF_FFFC sequential retire -> next imem_addr=0x0.
REQ-042 Check: finish_flag with instr_ready -> halted=1, no requests; then start -> fetch at RESET_PC; reset low during WAIT -> IDLE immediately and a later ack is ignored.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM state
// encoding and the default PC constants used by the sequencer top.
package riscv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_HALT = 3'd4
    } seq_state_t;

    localparam int unsigned DEFAULT_PC_STEP  = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: jump beats branch beats sequential.
// Redirect targets are word-aligned and a misaligned request is flagged.
module pc_next_calc #(
    parameter int unsigned PC_STEP = 4
) (
    input  logic [31:0] instr_pc_i,
    input  logic        branch_i,
    input  logic [31:0] branch_offset_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    output logic [31:0] next_pc_o,
    output logic        misalign_o
);

    logic [31:0] raw_target;
    logic        redirect;

    // Pick the raw target by priority, then clear the low bits of redirects
    always_comb begin
        raw_target = instr_pc_i + 32'(PC_STEP);
        redirect   = 1'b0;
        if (jump_i) begin
            raw_target = jump_target_i;
            redirect   = 1'b1;
        end else if (branch_i) begin
            raw_target = instr_pc_i + branch_offset_i;
            redirect   = 1'b1;
        end
        next_pc_o  = redirect ? {raw_target[31:2], 2'b00} : raw_target;
        misalign_o = redirect && (raw_target[1:0] != 2'b00);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: requests one instruction at a time from
// instruction memory, holds it for the consumer, and computes the next PC
// from the consumer's branch/jump/finish decision on retirement.
module pc_sequencer
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        finish_flag,
    input  logic        branch,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] retired_count
);

    seq_state_t  state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        req_q;
    logic        valid_q;
    logic        halted_q;
    logic        misalign_q;
    logic [31:0] retired_q;
    logic [31:0] next_pc_d;
    logic        misalign_d;

    pc_next_calc #(
        .PC_STEP(PC_STEP)
    ) u_pc_next_calc (
        .instr_pc_i      (instr_pc_q),
        .branch_i        (branch),
        .branch_offset_i (branch_offset),
        .jump_i          (jump),
        .jump_target_i   (jump_target),
        .next_pc_o       (next_pc_d),
        .misalign_o      (misalign_d)
    );

    // Fetch FSM with all outputs registered alongside the state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
            retired_q  <= 32'h0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        pc_q     <= RESET_PC;
                        req_q    <= 1'b1;
                        halted_q <= 1'b0;
                        state_q  <= ST_REQ;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    if (imem_ack) begin
                        instr_q    <= imem_rdata;
                        instr_pc_q <= pc_q;
                        req_q      <= 1'b0;
                        valid_q    <= 1'b1;
                        state_q    <= ST_HOLD;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (instr_ready) begin
                        retired_q <= retired_q + 32'd1;
                        valid_q   <= 1'b0;
                        if (finish_flag) begin
                            halted_q <= 1'b1;
                            state_q  <= ST_HALT;
                        end else begin
                            pc_q       <= next_pc_d;
                            misalign_q <= misalign_q | misalign_d;
                            req_q      <= 1'b1;
                            state_q    <= ST_REQ;
                        end
                    end
                end
                default: begin
                    req_q    <= 1'b0;
                    valid_q  <= 1'b0;
                    halted_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req      = req_q;
    assign imem_addr     = pc_q;
    assign instr         = instr_q;
    assign instr_pc      = instr_pc_q;
    assign instr_valid   = valid_q;
    assign halted        = halted_q;
    assign misalign_err  = misalign_q;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: hand-written fetch/retire sequences
// plus a table of redirect vectors with precomputed next fetch addresses.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        finish_flag;
    logic        branch;
    logic [31:0] branch_offset;
    logic        jump;
    logic [31:0] jump_target;
    logic        halted;
    logic        misalign_err;
    logic [31:0] retired_count;

    int checkCount;
    int passCount;
    logic [31:0] expRetired;

    typedef struct {
        logic [31:0] base;
        logic        br;
        logic [31:0] offset;
        logic        jmp;
        logic [31:0] target;
        logic [31:0] expAddr;
        logic        expMisalign;
    } vec_t;

    vec_t vecs [8];

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .finish_flag   (finish_flag),
        .branch        (branch),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .halted        (halted),
        .misalign_err  (misalign_err),
        .retired_count (retired_count)
    );

    // Free-running 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return addr ^ 32'hC0DE_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One cycle of consumer handshake inputs, cleared afterwards
    task automatic applyStimulus(input logic rdy, input logic fin, input logic br,
                                 input logic [31:0] off, input logic jmp, input logic [31:0] tgt);
        instr_ready   = rdy;
        finish_flag   = fin;
        branch        = br;
        branch_offset = off;
        jump          = jmp;
        jump_target   = tgt;
        tick();
        instr_ready   = 1'b0;
        finish_flag   = 1'b0;
        branch        = 1'b0;
        branch_offset = 32'h0;
        jump          = 1'b0;
        jump_target   = 32'h0;
        if (rdy) expRetired = expRetired + 32'd1;
    endtask

    task automatic ackFetch(input logic [31:0] data);
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Main directed test
    initial begin
        checkCount = 0;
        passCount  = 0;
        expRetired = 32'h0;
        reset = 1'b0;
        start = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        instr_ready = 1'b0;
        finish_flag = 1'b0;
        branch = 1'b0;
        branch_offset = 32'h0;
        jump = 1'b0;
        jump_target = 32'h0;

        vecs[0] = '{32'h0000_0010, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0,         32'h0000_0008, 1'b0};
        vecs[1] = '{32'h0000_0010, 1'b1, 32'hFFFF_FFF8, 1'b1, 32'h0000_0100, 32'h0000_0100, 1'b0};
        vecs[2] = '{32'hFFFF_FFFC, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0000, 1'b0};
        vecs[3] = '{32'h0000_0020, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0024, 1'b0};
        vecs[4] = '{32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         32'hFFFF_FFFC, 1'b0};
        vecs[5] = '{32'h0000_0040, 1'b1, 32'h0000_0020, 1'b0, 32'h0,         32'h0000_0060, 1'b0};
        vecs[6] = '{32'h0000_0080, 1'b0, 32'h0,         1'b1, 32'h0000_0102, 32'h0000_0100, 1'b1};
        vecs[7] = '{32'h0000_0200, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0204, 1'b1};

        // Reset state
        tick();
        tick();
        checkOutput("rst imem_req", {31'h0, imem_req}, 32'h0);
        checkOutput("rst instr_valid", {31'h0, instr_valid}, 32'h0);
        checkOutput("rst halted", {31'h0, halted}, 32'h0);
        checkOutput("rst retired", retired_count, 32'h0);
        checkOutput("rst instr", instr, 32'h0);
        reset = 1'b1;
        tick();
        checkOutput("idle no req", {31'h0, imem_req}, 32'h0);

        // Zero-wait fetches at 0, 4, 8
        pulseStart();
        checkOutput("start req", {31'h0, imem_req}, 32'h1);
        checkOutput("start addr", imem_addr, 32'h0);
        ackFetch(memWord(32'h0));
        checkOutput("hold valid", {31'h0, instr_valid}, 32'h1);
        checkOutput("hold instr", instr, memWord(32'h0));
        checkOutput("hold instr_pc", instr_pc, 32'h0);
        checkOutput("hold no req", {31'h0, imem_req}, 32'h0);
        pulseStart();
        checkOutput("start ignored valid", {31'h0, instr_valid}, 32'h1);
        checkOutput("start ignored pc", instr_pc, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("seq addr 4", imem_addr, 32'h4);
        checkOutput("seq req 4", {31'h0, imem_req}, 32'h1);
        ackFetch(memWord(32'h4));
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("seq addr 8", imem_addr, 32'h8);
        ackFetch(memWord(32'h8));
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("retired 3", retired_count, 32'd3);

        // Ack delayed by three cycles: request held stable for four
        for (int c = 0; c < 4; c++) begin
            checkOutput($sformatf("wait req c%0d", c), {31'h0, imem_req}, 32'h1);
            checkOutput($sformatf("wait addr c%0d", c), imem_addr, 32'hC);
            if (c < 3) tick();
        end
        checkOutput("ack cycle not valid", {31'h0, instr_valid}, 32'h0);
        ackFetch(memWord(32'hC));
        checkOutput("valid after ack", {31'h0, instr_valid}, 32'h1);
        checkOutput("delayed instr", instr, memWord(32'hC));

        // Redirect vectors: jump to base, fetch it, then retire with vector controls
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, vecs[i].base);
            checkOutput($sformatf("vec%0d base addr", i), imem_addr, vecs[i].base);
            ackFetch(memWord(vecs[i].base));
            checkOutput($sformatf("vec%0d instr_pc", i), instr_pc, vecs[i].base);
            applyStimulus(1'b1, 1'b0, vecs[i].br, vecs[i].offset, vecs[i].jmp, vecs[i].target);
            checkOutput($sformatf("vec%0d next addr", i), imem_addr, vecs[i].expAddr);
            checkOutput($sformatf("vec%0d misalign", i), {31'h0, misalign_err}, {31'h0, vecs[i].expMisalign});
            ackFetch(memWord(vecs[i].expAddr));
            checkOutput($sformatf("vec%0d instr", i), instr, memWord(vecs[i].expAddr));
        end
        checkOutput("retired after vecs", retired_count, expRetired);

        // Finish into HALT, then restart from RESET_PC
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0300);
        checkOutput("halted", {31'h0, halted}, 32'h1);
        checkOutput("halt no req", {31'h0, imem_req}, 32'h0);
        checkOutput("halt retired", retired_count, expRetired);
        tick();
        tick();
        checkOutput("halt still no req", {31'h0, imem_req}, 32'h0);
        pulseStart();
        checkOutput("restart req", {31'h0, imem_req}, 32'h1);
        checkOutput("restart addr", imem_addr, 32'h0);
        checkOutput("restart not halted", {31'h0, halted}, 32'h0);
        checkOutput("restart retired kept", retired_count, expRetired);
        checkOutput("misalign sticky", {31'h0, misalign_err}, 32'h1);

        // Reset asserted mid-WAIT takes effect without a clock edge
        tick();
        checkOutput("in wait req", {31'h0, imem_req}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async rst req", {31'h0, imem_req}, 32'h0);
        checkOutput("async rst retired", retired_count, 32'h0);
        checkOutput("async rst misalign", {31'h0, misalign_err}, 32'h0);
        checkOutput("async rst instr_pc", instr_pc, 32'h0);
        tick();
        reset = 1'b1;
        ackFetch(32'hDEAD_BEEF);
        checkOutput("late ack no valid", {31'h0, instr_valid}, 32'h0);
        checkOutput("late ack instr", instr, 32'h0);
        checkOutput("late ack no req", {31'h0, imem_req}, 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
